rectangle128_enc_core: RTL and testbench

Round-key store plus iterative RECTANGLE-128 encryption datapath, directly downstream of the key-schedule generator. Captures the 26 64-bit subkeys (K0..K25) written by the generator over its flush/WE/WAddr/KeyIn memory interface. Encrypts 64-bit blocks one round per clock behind valid/ready handshakes.

---
 rtl/rectangle128_enc_core.sv | 182 ++++++++++++++++++
 tb/tb_rectangle128_enc_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rectangle128_enc_core.sv
// RECTANGLE-128 round-key store and one-round-per-clock encryption core.
// Define RECT128_DEC_EN to add the `dec` input and the inverse (decryption) round.

module rectangle128_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
      4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
      4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
      4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
  end
endmodule

`ifdef RECT128_DEC_EN
// Table is the exact inverse of the forward S-box above.
module rectangle128_inv_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hF;  4'h3: y = 4'hA;
      4'h4: y = 4'hE;  4'h5: y = 4'h1;  4'h6: y = 4'h0;  4'h7: y = 4'h6;
      4'h8: y = 4'hC;  4'h9: y = 4'h7;  4'hA: y = 4'h3;  4'hB: y = 4'h8;
      4'hC: y = 4'h2;  4'hD: y = 4'hB;  4'hE: y = 4'h5;  4'hF: y = 4'hD;
      default: y = 4'h0;
    endcase
  end
endmodule
`endif

module rectangle128_enc_core #(
  parameter int NR = 25,
  parameter int NK = 26
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        flush,
  input  logic        WE,
  input  logic [4:0]  WAddr,
  input  logic [63:0] KeyIn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] pt_in,
`ifdef RECT128_DEC_EN
  input  logic        dec,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ct_out,
  output logic        keys_ready,
  output logic        busy
);
  localparam logic [4:0] LAST = 5'(NR - 1);
  localparam logic [4:0] NK_A = 5'(NK);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [4:0]       rnd, kidx;
  logic [63:0]      st, k_rnd, k_fin, enc_res, rnd_res;
  logic [63:0]      mem [NK];
  logic [NK-1:0]    key_vld, key_vld_nxt;
  logic             wr_ok, key_chg;
  logic [3:0][15:0] ex, sub;

  assign wr_ok   = WE && (WAddr < NK_A);
  assign key_chg = WE || !flush;
  assign k_rnd   = mem[kidx];
  assign k_fin   = mem[NR];

  assign in_ready = (state == IDLE) && keys_ready;
  assign busy     = (state != IDLE);

  // Writing subkey 0 marks the start of a fresh schedule, so older bits are stale.
  always_comb begin
    key_vld_nxt = key_vld;
    if (!flush) key_vld_nxt = '0;
    else if (wr_ok) begin
      if (WAddr == 5'd0) key_vld_nxt = '0;
      key_vld_nxt[WAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (flush && wr_ok) mem[WAddr] <= KeyIn;
  end

  // Forward round: AddRoundKey, SubColumn across 16 columns, ShiftRow.
  assign ex = st ^ k_rnd;
  for (genvar j = 0; j < 16; j++) begin : g_col
    logic [3:0] so;
    rectangle128_sbox u_sb (.x({ex[3][j], ex[2][j], ex[1][j], ex[0][j]}), .y(so));
    assign {sub[3][j], sub[2][j], sub[1][j], sub[0][j]} = so;
  end
  assign enc_res = {sub[3][2:0], sub[3][15:3], sub[2][3:0], sub[2][15:4],
                    sub[1][14:0], sub[1][15], sub[0]};

`ifdef RECT128_DEC_EN
  logic             dec_q;
  logic [3:0][15:0] iy, isub;
  logic [63:0]      dec_res;

  assign iy[0] = st[15:0];
  assign iy[1] = {st[16], st[31:17]};
  assign iy[2] = {st[43:32], st[47:44]};
  assign iy[3] = {st[60:48], st[63:61]};
  for (genvar j = 0; j < 16; j++) begin : g_icol
    logic [3:0] so;
    rectangle128_inv_sbox u_isb (.x({iy[3][j], iy[2][j], iy[1][j], iy[0][j]}), .y(so));
    assign {isub[3][j], isub[2][j], isub[1][j], isub[0][j]} = so;
  end
  assign dec_res = isub ^ k_rnd;
  assign kidx    = dec_q ? (LAST - rnd) : rnd;
  assign rnd_res = dec_q ? dec_res : enc_res;
`else
  assign kidx    = rnd;
  assign rnd_res = enc_res;
`endif

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      rnd        <= '0;
      st         <= '0;
      ct_out     <= '0;
      out_valid  <= 1'b0;
      key_vld    <= '0;
      keys_ready <= 1'b0;
`ifdef RECT128_DEC_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      key_vld    <= key_vld_nxt;
      keys_ready <= &key_vld_nxt;
      case (state)
        IDLE: if (in_valid && in_ready) begin
`ifdef RECT128_DEC_EN
          dec_q <= dec;
          st    <= dec ? (pt_in ^ k_fin) : pt_in;
`else
          st    <= pt_in;
`endif
          rnd   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (key_chg) begin
            // Schedule changed under us: the block in flight is discarded.
            rnd   <= '0;
            state <= IDLE;
          end else if (rnd == LAST) begin
`ifdef RECT128_DEC_EN
            ct_out <= dec_q ? rnd_res : (rnd_res ^ k_fin);
`else
            ct_out <= rnd_res ^ k_fin;
`endif
            st        <= rnd_res;
            rnd       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st  <= rnd_res;
            rnd <= rnd + 5'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rectangle128_enc_core.sv
// Scoreboard bench for rectangle128_enc_core: key store, encryption, DONE hold, abort, reset.
module tb_rectangle128_enc_core;
  localparam int NR = 25;
  localparam int NK = 26;

  logic        Clk = 1'b0, RstN = 1'b0, flush = 1'b1, WE = 1'b0;
  logic [4:0]  WAddr = '0;
  logic [63:0] KeyIn = '0, pt_in = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1, dec = 1'b0;
  logic        in_ready, out_valid, keys_ready, busy;
  logic [63:0] ct_out;

  rectangle128_enc_core dut (
    .Clk(Clk), .RstN(RstN), .flush(flush), .WE(WE), .WAddr(WAddr), .KeyIn(KeyIn),
    .in_valid(in_valid), .in_ready(in_ready), .pt_in(pt_in),
`ifdef RECT128_DEC_EN
    .dec(dec),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .ct_out(ct_out),
    .keys_ready(keys_ready), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [63:0] K [NK];
  logic [3:0]  SB [16];

  typedef struct { logic [63:0] ct; int acc; logic d; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] enc_model(input logic [63:0] p);
    logic [63:0] s, x;
    logic [15:0] r [4];
    logic [15:0] t [4];
    logic [3:0]  nib, y;
    s = p;
    for (int i = 0; i < NR; i++) begin
      x = s ^ K[i];
      for (int b = 0; b < 4; b++) r[b] = x[16*b +: 16];
      for (int j = 0; j < 16; j++) begin
        nib = {r[3][j], r[2][j], r[1][j], r[0][j]};
        y = SB[nib];
        for (int b = 0; b < 4; b++) t[b][j] = y[b];
      end
      t[1] = (t[1] << 1)  | (t[1] >> 15);
      t[2] = (t[2] << 12) | (t[2] >> 4);
      t[3] = (t[3] << 13) | (t[3] >> 3);
      s = {t[3], t[2], t[1], t[0]};
    end
    return s ^ K[NR];
  endfunction

  // Monitor: latency on first sight of out_valid, data on handshake.
  bit seen = 1'b0;
  always @(negedge Clk) begin
    if (!RstN) seen = 1'b0;
    else if (out_valid) begin
      if (exp_q.size() == 0) begin
        if (!seen) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out: got ct %h, expected no output", ct_out);
        end
        seen = !out_ready;
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - exp_q[0].acc), 64'd25);
          seen = 1'b1;
        end
        if (out_ready) begin
          chk(exp_q[0].d ? "pt_out_dec" : "ct_out", ct_out, exp_q[0].ct);
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  task automatic wkey(input logic [4:0] a, input logic [63:0] k);
    WE = 1'b1; WAddr = a; KeyIn = k;
    step();
    WE = 1'b0;
  endtask

  task automatic load_keys();
    for (int i = 0; i < NK; i++) wkey(5'(i), K[i]);
  endtask

  task automatic send(input logic [63:0] p, input logic d, input logic [63:0] e, input bit push);
    int t = 0;
    while (!in_ready && t < 100) begin step(); t++; end
    if (!in_ready) begin
      chk("in_ready_wait", 64'(in_ready), 64'd1);
      return;
    end
    pt_in = p; dec = d; in_valid = 1'b1;
    if (push) exp_q.push_back('{e, cyc + 1, dec});
    step();
    in_valid = 1'b0; dec = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || out_valid) && t < 200) begin step(); t++; end
    if (busy || out_valid) chk("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] vec [3];
    logic [63:0] e;
    int cnt;
    SB = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
           4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
    for (int i = 0; i < NK; i++) K[i] = 64'h0F1E_2D3C_4B5A_6978 ^ {8{8'(i)}};
    vec = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};

    step(2);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ct_out", ct_out, 64'd0);
    chk("rst_keys_ready", 64'(keys_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    RstN = 1'b1;
    step();

    for (int i = 0; i < NK - 1; i++) wkey(5'(i), K[i]);
    chk("keys_ready_partial", 64'(keys_ready), 64'd0);
    wkey(5'd25, K[25]);
    chk("keys_ready_full", 64'(keys_ready), 64'd1);
    chk("in_ready_keys", 64'(in_ready), 64'd1);
    wkey(5'd31, '1);
    chk("waddr_oob_ignored", 64'(keys_ready), 64'd1);

    flush = 1'b0; step(); flush = 1'b1;
    chk("flush_clears", 64'(keys_ready), 64'd0);
    load_keys();
    chk("reload_ready", 64'(keys_ready), 64'd1);
    wkey(5'd0, K[0]);
    chk("waddr0_restart", 64'(keys_ready), 64'd0);
    chk("waddr0_in_ready", 64'(in_ready), 64'd0);
    load_keys();

    for (int v = 0; v < 3; v++) begin
      send(vec[v], 1'b0, enc_model(vec[v]), 1'b1);
      if (v == 0) begin
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd0);
      end
      wait_idle();
    end

    // Consumer stalls in DONE.
    out_ready = 1'b0;
    e = enc_model(64'hDEAD_BEEF_0BAD_F00D);
    send(64'hDEAD_BEEF_0BAD_F00D, 1'b0, e, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin step(); cnt++; end
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_ct_out", ct_out, e);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // Key write during round 10 aborts the block.
    send(64'h1111_2222_3333_4444, 1'b0, 64'd0, 1'b0);
    step(10);
    WE = 1'b1; WAddr = 5'd3; KeyIn = K[3];
    step();
    WE = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_keys_ready", 64'(keys_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    cnt = 0;
    repeat (30) begin step(); if (out_valid) cnt++; end
    chk("abort_no_out", 64'(cnt), 64'd0);
    send(vec[2], 1'b0, enc_model(vec[2]), 1'b1);
    wait_idle();

`ifdef RECT128_DEC_EN
    send(enc_model(vec[2]), 1'b1, vec[2], 1'b1);
    wait_idle();
`endif

    // Asynchronous reset in the middle of a block.
    send(64'h5555_AAAA_5555_AAAA, 1'b0, 64'd0, 1'b0);
    step(12);
    RstN = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_ct_out", ct_out, 64'd0);
    chk("arst_keys_ready", 64'(keys_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    step();
    RstN = 1'b1;
    step();
    chk("post_rst_keys_ready", 64'(keys_ready), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd0);

    step(5);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
